// File: rtl/async_fifo_wside_pkg.sv
// async_fifo_wside_pkg: shared CDC helpers for the dual-clock FIFO pointer logic
package async_fifo_wside_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int GW = 32;

    // Operands narrower than GW are zero-extended, so the result's low bits are valid at any width.
    function automatic logic [GW-1:0] bin_to_gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its own and all higher Gray bits.
    function automatic logic [GW-1:0] gray_to_bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_bin_cnt.sv
// gray_bin_cnt: binary + Gray dual counter with registered Gray output
module gray_bin_cnt
    import async_fifo_wside_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count_bin,
    output logic [W-1:0] count_gry
);

    logic [W-1:0] bin_nxt;

    assign bin_nxt = count_bin + W'(1);

    // Advance both encodings together so the Gray output is a clean flop with one bit change per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_bin <= '0;
            count_gry <= '0;
        end else if (clr) begin
            count_bin <= '0;
            count_gry <= '0;
        end else if (en) begin
            count_bin <= bin_nxt;
            count_gry <= W'(bin_to_gray(GW'(bin_nxt)));
        end
    end

endmodule

// File: rtl/sync_bus_gray.sv
// sync_bus_gray: multi-flop synchroniser for a Gray-coded bus crossing into this clock domain
module sync_bus_gray
    import async_fifo_wside_pkg::*;
#(
    parameter int W      = 4,
    parameter int STAGES = MIN_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    (* keep = "true", dont_retime = "true", async_reg = "true" *)
    logic [W-1:0] sync_q [STAGES];

    // Plain flop chain; Gray coding guarantees at most one bit is in flight per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wside.sv
// async_fifo_wside: write-domain control of a dual-clock FIFO (pointer, full, fill level)
module async_fifo_wside
    import async_fifo_wside_pkg::*;
#(
    parameter int W_DATA      = 32,
    parameter int W_ADDR      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_DATA-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic              full,
    output logic [W_ADDR:0]   level,
    output logic              ram_wen,
    output logic [W_ADDR-1:0] ram_waddr,
    output logic [W_DATA-1:0] ram_wdata,
    output logic [W_ADDR:0]   wptr_gry,
    input  logic [W_ADDR:0]   rptr_gry
);

    localparam int W_PTR = W_ADDR + 1;

    logic             push;
    logic [W_PTR-1:0] wptr_bin;
    logic [W_PTR-1:0] rptr_s;
    logic [W_PTR-1:0] rptr_bin_s;

    gray_bin_cnt #(.W(W_PTR)) u_wptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (push),
        .clr      (1'b0),
        .count_bin(wptr_bin),
        .count_gry(wptr_gry)
    );

    sync_bus_gray #(.W(W_PTR), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (rptr_gry),
        .dout (rptr_s)
    );

    // Full and level come only from flop outputs, so wvalid never reaches them combinationally.
    always_comb begin
        rptr_bin_s = W_PTR'(gray_to_bin(GW'(rptr_s)));
        full       = wptr_gry == {~rptr_s[W_ADDR:W_ADDR-1], rptr_s[W_ADDR-2:0]};
        level      = wptr_bin - rptr_bin_s;
        wready     = !full;
        push       = wvalid && wready;
        ram_wen    = push;
        ram_waddr  = wptr_bin[W_ADDR-1:0];
        ram_wdata  = wdata;
    end

endmodule
